// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase scheduler.
// Phase codes, lamp bit positions and the per-road lamp decode.
package traffic_pkg;

  typedef enum logic [2:0] {
    P_GA  = 3'd0,
    P_YA  = 3'd1,
    P_ARA = 3'd2,
    P_GB  = 3'd3,
    P_YB  = 3'd4,
    P_ARB = 3'd5
  } phase_e;

  localparam int L_R   = 0;
  localparam int L_Y   = 1;
  localparam int L_G   = 2;
  localparam int NLAMP = 3;

  // Exactly one lamp lit: red unless green or yellow is selected.
  function automatic logic [NLAMP-1:0] lamp_decode(
    input logic g,
    input logic y
  );
    logic [NLAMP-1:0] l;
    l        = '0;
    l[L_G]   = g;
    l[L_Y]   = y;
    l[L_R]   = ~(g | y);
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle for the phase scheduler: sensor/request inputs and
// lamp/walk outputs, seen from the controller side and the block side.
interface traffic_phase_scheduler_if;

  logic       tick;
  logic       ta;
  logic       tb;
  logic       pa;
  logic       pb;
  logic       ra;
  logic       ya;
  logic       ga;
  logic       rb;
  logic       yb;
  logic       gb;
  logic       walk_a;
  logic       walk_b;
  logic [2:0] phase;

  modport master (
    output tick, ta, tb, pa, pb,
    input  ra, ya, ga, rb, yb, gb,
    input  walk_a, walk_b, phase
  );

  modport slave (
    input  tick, ta, tb, pa, pb,
    output ra, ya, ga, rb, yb, gb,
    output walk_a, walk_b, phase
  );

endinterface

// File: rtl/phase_timer.sv
// Dwell timer: counts ticks since the last phase change and
// saturates at all-ones so a long idle green keeps its maximum.
module phase_timer #(
  parameter int TW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          clear,
  output logic [TW-1:0] t
);

  localparam logic [TW-1:0] T_MAX = '1;

  logic [TW-1:0] t_d;
  logic [TW-1:0] t_q;

  // Clear wins over count; count holds at the saturation value.
  always_comb begin
    t_d = t_q;
    if (clear) begin
      t_d = '0;
    end else if (tick && (t_q != T_MAX)) begin
      t_d = t_q + 1'b1;
    end
  end

  // Timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= '0;
    end else begin
      t_q <= t_d;
    end
  end

  assign t = t_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection sequencer: phase FSM with min/max green,
// yellow and all-red dwells, pedestrian latches and lamp/walk decode.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int TW        = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       TA,
  input  logic       TB,
  input  logic       PA,
  input  logic       PB,
  output logic       RA,
  output logic       YA,
  output logic       GA,
  output logic       RB,
  output logic       YB,
  output logic       GB,
  output logic       WALK_A,
  output logic       WALK_B,
  output logic [2:0] phase
);

  localparam logic [TW-1:0] MIN_M1 = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_M1 = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_M1 = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AR_M1  = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] MIN_T  = TW'(MIN_GREEN);

  phase_e        phase_d;
  phase_e        phase_q;
  logic          pend_a_d;
  logic          pend_a_q;
  logic          pend_b_d;
  logic          pend_b_q;
  logic [TW-1:0] t;
  logic          t_clear;
  logic          demand_a;
  logic          demand_b;
  logic          ga_done;
  logic          gb_done;
  logic [NLAMP-1:0] lamp_a;
  logic [NLAMP-1:0] lamp_b;

  assign demand_a = TA | pend_a_q;
  assign demand_b = TB | pend_b_q;

  assign ga_done = demand_b &
    (((t >= MIN_M1) & ~TA) | (t >= MAX_M1));
  assign gb_done = demand_a &
    (((t >= MIN_M1) & ~TB) | (t >= MAX_M1));

  assign t_clear = (phase_d != phase_q);

  phase_timer #(
    .TW(TW)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .clear(t_clear),
    .t    (t)
  );

  // Next phase: legal phases move only on tick, illegal codes
  // fall back to A green on the next clock regardless of tick.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      P_GA:  if (tick && ga_done)      phase_d = P_YA;
      P_YA:  if (tick && t == YEL_M1)  phase_d = P_ARA;
      P_ARA: if (tick && t == AR_M1)   phase_d = P_GB;
      P_GB:  if (tick && gb_done)      phase_d = P_YB;
      P_YB:  if (tick && t == YEL_M1)  phase_d = P_ARB;
      P_ARB: if (tick && t == AR_M1)   phase_d = P_GA;
      default:                         phase_d = P_GA;
    endcase
  end

  // Pedestrian latches: capture any cycle, clear on entry to
  // the matching green; the clear wins over a same-cycle set.
  always_comb begin
    pend_a_d = pend_a_q | PA;
    pend_b_d = pend_b_q | PB;
    if ((phase_d == P_GA) && (phase_q != P_GA)) begin
      pend_a_d = 1'b0;
    end
    if ((phase_d == P_GB) && (phase_q != P_GB)) begin
      pend_b_d = 1'b0;
    end
  end

  // Phase and pending-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= P_GA;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
    end
  end

  assign lamp_a = lamp_decode(phase_q == P_GA, phase_q == P_YA);
  assign lamp_b = lamp_decode(phase_q == P_GB, phase_q == P_YB);

  assign RA = lamp_a[L_R];
  assign YA = lamp_a[L_Y];
  assign GA = lamp_a[L_G];
  assign RB = lamp_b[L_R];
  assign YB = lamp_b[L_Y];
  assign GB = lamp_b[L_G];

  assign WALK_A = (phase_q == P_GA) & (t < MIN_T);
  assign WALK_B = (phase_q == P_GB) & (t < MIN_T);

  assign phase = phase_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scenario bench for traffic_phase_scheduler: expected per-cycle
// phase/lamp/walk values are queued up front and popped each cycle.
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;

  typedef struct packed {
    logic [2:0] ph;
    logic [5:0] lamps;
    logic [1:0] walk;
  } exp_t;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  exp_t sb[$];

  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler #(
    .MIN_GREEN(8),
    .MAX_GREEN(30),
    .YELLOW_T (3),
    .ALLRED_T (1),
    .TW       (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (bus.tick),
    .TA    (bus.ta),
    .TB    (bus.tb),
    .PA    (bus.pa),
    .PB    (bus.pb),
    .RA    (bus.ra),
    .YA    (bus.ya),
    .GA    (bus.ga),
    .RB    (bus.rb),
    .YB    (bus.yb),
    .GB    (bus.gb),
    .WALK_A(bus.walk_a),
    .WALK_B(bus.walk_b),
    .phase (bus.phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded, got no finish want finish");
    $fatal(1);
  end

  // {RA,YA,GA,RB,YB,GB}
  function automatic logic [5:0] lamps_of(input logic [2:0] p);
    case (p)
      3'd0:    return 6'b001_100;
      3'd1:    return 6'b010_100;
      3'd2:    return 6'b100_100;
      3'd3:    return 6'b100_001;
      3'd4:    return 6'b100_010;
      3'd5:    return 6'b100_100;
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic push_seq(input logic [2:0] p, input int n,
                          input int nwalk);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.ph    = p;
      e.lamps = lamps_of(p);
      e.walk  = 2'b00;
      if (i < nwalk && p == 3'd0) e.walk = 2'b01;
      if (i < nwalk && p == 3'd3) e.walk = 2'b10;
      sb.push_back(e);
    end
  endtask

  function automatic exp_t observe();
    return exp_t'({bus.phase,
                   bus.ra, bus.ya, bus.ga,
                   bus.rb, bus.yb, bus.gb,
                   bus.walk_b, bus.walk_a});
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.tick = 1'b1;
    bus.ta   = 1'b0;
    bus.tb   = 1'b0;
    bus.pa   = 1'b0;
    bus.pb   = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (observe() !== exp_t'({3'd0, 6'b001_100, 2'b01}))
      $display("FAIL reset_state got %h want %h",
               observe(), exp_t'({3'd0, 6'b001_100, 2'b01}));
    else passed++;
  endtask

  task automatic test_idle();
    exp_t e;
    int   n;
    do_reset();
    push_seq(3'd0, 101, 8);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = sb.pop_front();
      total++;
      if (observe() !== e)
        $display("FAIL idle cyc%0d got %h want %h", i, observe(), e);
      else passed++;
    end
  endtask

  task automatic test_b_demand();
    exp_t e;
    int   n;
    do_reset();
    bus.tb = 1'b1;
    push_seq(3'd0, 8, 8);
    push_seq(3'd1, 3, 0);
    push_seq(3'd2, 1, 0);
    push_seq(3'd3, 29, 8);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = sb.pop_front();
      total++;
      if (observe() !== e)
        $display("FAIL b_demand cyc%0d got %h want %h",
                 i, observe(), e);
      else passed++;
    end
  endtask

  task automatic test_contested();
    exp_t e;
    int   n;
    do_reset();
    bus.ta = 1'b1;
    bus.tb = 1'b1;
    push_seq(3'd0, 30, 8);
    push_seq(3'd1, 3, 0);
    push_seq(3'd2, 1, 0);
    push_seq(3'd3, 30, 8);
    push_seq(3'd4, 3, 0);
    push_seq(3'd5, 1, 0);
    push_seq(3'd0, 30, 8);
    push_seq(3'd1, 1, 0);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = sb.pop_front();
      total++;
      if (observe() !== e)
        $display("FAIL contested cyc%0d got %h want %h",
                 i, observe(), e);
      else passed++;
    end
  endtask

  task automatic test_pedestrian();
    exp_t e;
    int   n;
    do_reset();
    push_seq(3'd0, 8, 8);
    push_seq(3'd1, 3, 0);
    push_seq(3'd2, 1, 0);
    push_seq(3'd3, 14, 8);
    push_seq(3'd4, 3, 0);
    push_seq(3'd5, 1, 0);
    push_seq(3'd0, 20, 8);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        bus.pb = (i == 2);
        bus.pa = (i == 25);
        @(posedge clk);
        #1;
      end
      e = sb.pop_front();
      total++;
      if (observe() !== e)
        $display("FAIL pedestrian cyc%0d got %h want %h",
                 i, observe(), e);
      else passed++;
    end
    bus.pa = 1'b0;
    bus.pb = 1'b0;
  endtask

  task automatic test_tick_freeze();
    exp_t e;
    int   n;
    do_reset();
    bus.tb = 1'b1;
    push_seq(3'd0, 8, 8);
    push_seq(3'd1, 23, 0);
    push_seq(3'd2, 1, 0);
    push_seq(3'd3, 10, 8);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        bus.tick = !(i >= 10 && i <= 29);
        @(posedge clk);
        #1;
      end
      e = sb.pop_front();
      total++;
      if (observe() !== e)
        $display("FAIL tick_freeze cyc%0d got %h want %h",
                 i, observe(), e);
      else passed++;
    end
    bus.tick = 1'b1;
  endtask

  task automatic test_saturation();
    exp_t e;
    int   n;
    do_reset();
    bus.ta = 1'b1;
    push_seq(3'd0, 71, 8);
    push_seq(3'd1, 3, 0);
    push_seq(3'd2, 1, 0);
    push_seq(3'd3, 5, 8);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        bus.tb = (i >= 71);
        @(posedge clk);
        #1;
      end
      e = sb.pop_front();
      total++;
      if (observe() !== e)
        $display("FAIL saturation cyc%0d got %h want %h",
                 i, observe(), e);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.tb = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    total++;
    if (observe() !== exp_t'({3'd1, 6'b010_100, 2'b00}))
      $display("FAIL pre_reset_yellow got %h want %h",
               observe(), exp_t'({3'd1, 6'b010_100, 2'b00}));
    else passed++;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (observe() !== exp_t'({3'd0, 6'b001_100, 2'b01}))
      $display("FAIL async_reset got %h want %h",
               observe(), exp_t'({3'd0, 6'b001_100, 2'b01}));
    else passed++;
  endtask

  task automatic test_illegal_phase();
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    force dut.phase_q = phase_e'(3'd6);
    #1;
    total++;
    if (observe() !== exp_t'({3'd6, 6'b100_100, 2'b00}))
      $display("FAIL illegal_decode got %h want %h",
               observe(), exp_t'({3'd6, 6'b100_100, 2'b00}));
    else passed++;
    #2;
    release dut.phase_q;
    @(posedge clk);
    #1;
    total++;
    if (bus.phase !== 3'd0 || bus.ga !== 1'b1 || bus.rb !== 1'b1)
      $display("FAIL illegal_recover got ph=%0d ga=%b rb=%b want ph=0 ga=1 rb=1",
               bus.phase, bus.ga, bus.rb);
    else passed++;
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    rst_n    = 1'b0;
    bus.tick = 1'b1;
    bus.ta   = 1'b0;
    bus.tb   = 1'b0;
    bus.pa   = 1'b0;
    bus.pb   = 1'b0;
    test_reset();
    test_idle();
    test_b_demand();
    test_contested();
    test_pedestrian();
    test_tick_freeze();
    test_saturation();
    test_async_reset();
    test_illegal_phase();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Timed two-road intersection sequencer that decides when right-of-way moves between road A and road B. It uses vehicle sensors, latched pedestrian requests and a prescaled tick to enforce minimum green, maximum green, yellow and all-red clearance dwells. It drives the six lamp outputs plus walk indications directly and sits above the lamp drivers in the intersection top level.

## Interface
Parameters:
- MIN_GREEN, 8: minimum green dwell in ticks; also the walk window. Must be ≥1.
- MAX_GREEN, 30: green dwell, in ticks, after which a contested green is forced to end. Must be ≥MIN_GREEN and ≤2^TW−1.
- YELLOW_T, 3: yellow dwell in ticks. Must be ≥1.
- ALLRED_T, 1: all-red clearance dwell in ticks. Must be ≥1.
- TW, 6: dwell-timer width.

Ports:
- clk, in, 1: clock. One clock domain.
- rst_n, in, 1: asynchronous active-low reset.
- tick, in, 1: one-cycle time-base enable. Timer and FSM advance only on cycles with tick=1.
- TA, in, 1: vehicle present on road A (level).
- TB, in, 1: vehicle present on road B (level).
- PA, in, 1: pedestrian request for the A green (pulse, any cycle).
- PB, in, 1: pedestrian request for the B green (pulse, any cycle).
- RA, YA, GA, out, 1 each: road A lamps.
- RB, YB, GB, out, 1 each: road B lamps.
- WALK_A, out, 1: walk indication aligned with the A green.
- WALK_B, out, 1: walk indication aligned with the B green.
- phase, out, 3: current phase code.

## Operation
- Phases cycle in fixed order: P_GA → P_YA → P_ARA → P_GB → P_YB → P_ARB → P_GA.
  - P_ARA and P_ARB are all-red phases.
- Dwell timer t:
  - Cleared to 0 on every phase transition.
  - Otherwise increments on tick and saturates at 2^TW−1.
- Transitions are evaluated only on tick cycles, using the current value of t.
- Pending latches pend_A and pend_B:
  - pend_A is set by PA and cleared on the transition into P_GA.
  - pend_B is set by PB and cleared on the transition into P_GB.
  - If a set and the clear occur in the same cycle, the clear wins.
- P_GA exit condition: demand_B = TB | pend_B must hold, and either of:
  - t ≥ MIN_GREEN−1 and TA=0, or
  - t ≥ MAX_GREEN−1.
- With no demand_B, P_GA holds indefinitely.
- P_GB is symmetric, with demand_A = TA | pend_A and extension by TB.
- P_YA and P_YB exit when t = YELLOW_T−1.
- P_ARA and P_ARB exit when t = ALLRED_T−1.
- Lamp decode (combinational from phase):
  - GA only in P_GA; YA only in P_YA; RA in the other four phases.
  - B lamps mirror this: GB only in P_GB; YB only in P_YB; RB in the other four phases.
  - Exactly one lamp per road is high at all times.
- Walk decode:
  - WALK_A = (phase==P_GA) & (t < MIN_GREEN).
  - WALK_B = (phase==P_GB) & (t < MIN_GREEN).

## Timing
- Reset values:
  - Internal: phase=P_GA, t=0, pend_A=pend_B=0.
  - Outputs: GA=1, RB=1, WALK_A=1; RA, YA, YB, GB, WALK_B = 0; phase=3'd0.
- Reset is asynchronous mid-phase: it returns immediately to the reset state, discarding t and both pending latches.
- Lamp outputs change in the cycle after the tick edge that causes the transition.
- Dwell counts, with tick every cycle:
  - Yellow lasts exactly YELLOW_T cycles.
  - All-red lasts exactly ALLRED_T cycles.
  - A contested green lasts between MIN_GREEN and MAX_GREEN cycles.
- When tick is not every cycle, multiply these dwells by the tick period.
- tick=0 freezes phase and t. Pending latches still capture PA and PB.
- Sensor inputs are sampled synchronously with no internal synchronizer; the integration layer supplies synchronized inputs.
- t saturation: an uncontested green left for more than 2^TW−1 ticks keeps t at its maximum. When demand then arrives, the green exits on the next tick, because t ≥ MAX_GREEN−1.

## Structure
- Shared package traffic_pkg holds:
  - Phase codes: P_GA=0, P_YA=1, P_ARA=2, P_GB=3, P_YB=4, P_ARB=5. Codes 6 and 7 are illegal and recover to P_GA on the next clock.
  - Lamp index constants.
- One sub-module, phase_timer:
  - TW-bit saturating counter.
  - Inputs: tick, clear.
  - Output: t.
- Top-level content: the phase FSM, pending latches, and lamp/walk decode.

## Test plan
1. Parameter setup for all scenarios: tick every cycle, MIN_GREEN=8, MAX_GREEN=30, YELLOW_T=3, ALLRED_T=1.
2. Reset, then TA=0, TB=0 for 100 cycles → phase stays P_GA; GA=1 and RB=1 throughout; WALK_A is high for 8 cycles, then low.
3. TB=1 from reset, TA=0 → GA lasts 8 cycles; YA lasts 3; all-red lasts 1; GB rises on cycle 13 after reset release; WALK_B is high for the first 8 cycles of GB.
4. TA=1 and TB=1 held → GA lasts exactly 30 cycles before YA. The sequence then alternates, with each green lasting 30 cycles.
5. Single-cycle PB pulse in cycle 2 of GA, with TB=0 and TA=0 → GA ends at 8 cycles and GB follows. pend_B is clear after GB entry, so GB holds with no further demand.
6. Boundary and recovery checks:
   - Assert rst_n low during P_YA → GA=1 and RB=1 immediately, with no clock needed.
   - Force phase to 6 → P_GA on the next clock.
   - Hold tick low for 20 cycles during yellow → no dwell advance.
